// File: rtl/dmem_pkg.sv
// Shared encodings and FSM state type for the data-memory responder.
// No logic, so no latency.
// No backpressure; constants and types only.
package dmem_pkg;

    // Store size encodings (DMS_mux)
    localparam logic [1:0] DMS_WORD = 2'b00;
    localparam logic [1:0] DMS_HALF = 2'b01;
    localparam logic [1:0] DMS_BYTE = 2'b10;
    localparam logic [1:0] DMS_RSV  = 2'b11;

    // Load type encodings (DML_mux); anything above DML_LBU is reserved
    localparam logic [2:0] DML_LW  = 3'b000;
    localparam logic [2:0] DML_LH  = 3'b001;
    localparam logic [2:0] DML_LHU = 3'b010;
    localparam logic [2:0] DML_LB  = 3'b011;
    localparam logic [2:0] DML_LBU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane store merge and load extract/extend for one 32-bit word.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  dms_i,
    input  logic [2:0]  dml_i,
    input  logic [1:0]  byte_off_i,
    output logic [31:0] new_word_o,
    output logic [31:0] load_data_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    assign half_sel = byte_off_i[1] ? old_word_i[31:16] : old_word_i[15:0];
    assign byte_sel = old_word_i[{byte_off_i, 3'b000} +: 8];

    // Store merge: replace only the selected lanes, keep the rest of the old word
    always_comb begin
        new_word_o = old_word_i;
        case (dms_i)
            DMS_WORD: new_word_o = wdata_i;
            DMS_HALF: begin
                if (byte_off_i[1]) new_word_o[31:16] = wdata_i[15:0];
                else               new_word_o[15:0]  = wdata_i[15:0];
            end
            DMS_BYTE: new_word_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
            default:  new_word_o = old_word_i;
        endcase
    end

    // Load extract: pick the lane and sign- or zero-extend to 32 bits
    always_comb begin
        load_data_o = '0;
        case (dml_i)
            DML_LW:  load_data_o = old_word_i;
            DML_LH:  load_data_o = {{16{half_sel[15]}}, half_sel};
            DML_LHU: load_data_o = {16'h0000, half_sel};
            DML_LB:  load_data_o = {{24{byte_sel[7]}}, byte_sel};
            DML_LBU: load_data_o = {24'h000000, byte_sel};
            default: load_data_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one load/store at a time with byte-lane merge and fault flags.
// Latency: ack is high LATENCY edges after the accepting edge, for one cycle.
// Backpressure: ready low from acceptance through the ack cycle; req ignored then.
// DMEM_ALIGN_CHECK_EN: when defined, misaligned word/half accesses raise err.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        DM_W,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  DMS_mux,
    input  logic [2:0]  DML_mux,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam int          CNT_W    = $clog2(LATENCY + 1);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [1:0]         dms_q;
    logic [2:0]         dml_q;
    logic               ready_q;
    logic               ack_q;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [IDX_W-1:0]   idx;
    logic [31:0]        old_word;
    logic [31:0]        new_word;
    logic [31:0]        load_data;
    logic               oor;
    logic               rsv;
    logic               mis;
    logic               fault;
    logic               resp_edge;
    logic               mem_we;

    // Base is word aligned, so the low index bits subtract without borrow from below
    assign idx      = addr_q[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
    assign old_word = mem[idx];

    assign oor = ({1'b0, addr_q} < {1'b0, BASE_ADDR}) || ({1'b0, addr_q} >= END_ADDR);
    assign rsv = we_q ? (dms_q == DMS_RSV) : (dml_q > DML_LBU);
`ifdef DMEM_ALIGN_CHECK_EN
    assign mis = we_q ? (((dms_q == DMS_WORD) && (addr_q[1:0] != 2'b00)) ||
                         ((dms_q == DMS_HALF) && addr_q[0]))
                      : (((dml_q == DML_LW) && (addr_q[1:0] != 2'b00)) ||
                         (((dml_q == DML_LH) || (dml_q == DML_LHU)) && addr_q[0]));
`else
    // Without the check, the lane logic simply ignores the low address bits
    assign mis = 1'b0;
`endif
    assign fault = oor || rsv || mis;

    assign resp_edge = (state_q == ST_WAIT) && (cnt_q == '0);
    assign mem_we    = resp_edge && we_q && !fault;

    dmem_lane u_lane (
        .old_word_i  (old_word),
        .wdata_i     (wdata_q),
        .dms_i       (dms_q),
        .dml_i       (dml_q),
        .byte_off_i  (addr_q[1:0]),
        .new_word_o  (new_word),
        .load_data_o (load_data)
    );

    // Handshake FSM, latency counter, request capture and registered response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dms_q   <= DMS_WORD;
            dml_q   <= DML_LW;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= DM_W;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        dms_q   <= DMS_mux;
                        dml_q   <= DML_mux;
                        ready_q <= 1'b0;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        ack_q   <= 1'b1;
                        err_q   <= fault;
                        rdata_q <= (fault || we_q) ? 32'h0 : load_data;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    ack_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory array is deliberately not reset; the write lands on the RESP-entry edge
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= new_word;
    end

    assign ready = ready_q;
    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed table, hand sequences, random vs byte-level model.
// Outputs sampled 1 time unit after the rising edge; inputs driven on the falling edge.
// Model tracks memory as a byte array with written flags.
module tb_dmem_resp;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] B     = 32'h1001_0000;
    localparam int          LAT   = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk, rst, req, DM_W;
    logic [31:0] addr, wdata;
    logic [1:0]  DMS_mux;
    logic [2:0]  DML_mux;
    logic        ready, ack, err;
    logic [31:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mb [4*DEPTH];
    bit         mv [4*DEPTH];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
        logic [2:0]  l;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];

    dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(B), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .DM_W(DM_W), .addr(addr), .wdata(wdata),
        .DMS_mux(DMS_mux), .DML_mux(DML_mux), .ready(ready), .ack(ack),
        .rdata(rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(logic w, logic [31:0] a, logic [31:0] d, logic [1:0] s,
                                logic [2:0] l, logic [31:0] erd, logic eerr);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.s = s; v.l = l; v.erd = erd; v.eerr = eerr;
        return v;
    endfunction

    // Reference: decode size, check faults, then read/write little-endian bytes
    task automatic ref_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] s, input logic [2:0] l,
                              output logic [31:0] rd, output logic e, output bit known);
        int sz; bit rsv; bit sgn; bit mis; bit oor;
        longint off; longint ea; longint v;
        sz = 4; rsv = 0; sgn = 0; known = 1; rd = 32'h0;
        if (w) begin
            case (s)
                2'd0: sz = 4;
                2'd1: sz = 2;
                2'd2: sz = 1;
                default: rsv = 1;
            endcase
        end else begin
            case (l)
                3'd0: sz = 4;
                3'd1: begin sz = 2; sgn = 1; end
                3'd2: sz = 2;
                3'd3: begin sz = 1; sgn = 1; end
                3'd4: sz = 1;
                default: rsv = 1;
            endcase
        end
        off = longint'(a) - longint'(B);
        oor = (off < 0) || (off >= 4 * DEPTH);
        mis = ALIGN && ((a & 32'(sz - 1)) != 32'h0);
        e = oor || rsv || mis;
        if (!e) begin
            ea = off - (off % sz);
            if (w) begin
                for (int i = 0; i < sz; i++) begin
                    mb[int'(ea) + i] = d[8*i +: 8];
                    mv[int'(ea) + i] = 1'b1;
                end
            end else begin
                v = 0;
                for (int i = 0; i < sz; i++) begin
                    if (!mv[int'(ea) + i]) known = 0;
                    v = v + (longint'(mb[int'(ea) + i]) << (8 * i));
                end
                if (sgn && v >= (longint'(1) << (8 * sz - 1)))
                    v = v - (longint'(1) << (8 * sz));
                rd = v[31:0];
            end
        end
    endtask

    // One full handshake; checks ack latency, single-cycle ack and ready return
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic [2:0] l,
                       output logic [31:0] rd, output logic e);
        int k; int lat;
        rd = 32'h0; e = 1'b0; lat = 0;
        @(negedge clk);
        k = 0;
        while (!ready && k < 50) begin @(negedge clk); k++; end
        req = 1'b1; DM_W = w; addr = a; wdata = d; DMS_mux = s; DML_mux = l;
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (ack) begin lat = i; rd = rdata; e = err; end
        end
        chk("ack_latency", 32'(lat), 32'(LAT));
        @(posedge clk); #1;
        chk("ack_one_cycle", {31'h0, ack}, 32'h0);
        chk("ready_after_ack", {31'h0, ready}, 32'h1);
    endtask

    initial begin
        logic [31:0] rd, mrd; logic e, me; bit known;
        int acc, acks;

        rst = 1'b0; req = 1'b0; DM_W = 1'b0; addr = '0; wdata = '0;
        DMS_mux = '0; DML_mux = '0;
        #12;
        chk("reset_ready", {31'h0, ready}, 32'h1);
        chk("reset_ack",   {31'h0, ack},   32'h0);
        chk("reset_rdata", rdata,          32'h0);
        chk("reset_err",   {31'h0, err},   32'h0);
        @(negedge clk); rst = 1'b1;

        // Directed vectors
        tbl.push_back(mk(1, B+4, 32'hDEADBEEF, 2'd0, 3'd0, 32'h0, 0));
        tbl.push_back(mk(0, B+4, 32'h0, 2'd0, 3'd0, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1, B+5, 32'h00000080, 2'd2, 3'd0, 32'h0, 0));
        tbl.push_back(mk(0, B+5, 32'h0, 2'd0, 3'd3, 32'hFFFFFF80, 0));
        tbl.push_back(mk(0, B+5, 32'h0, 2'd0, 3'd4, 32'h00000080, 0));
        tbl.push_back(mk(0, B+4, 32'h0, 2'd0, 3'd0, 32'hDEAD80EF, 0));
        tbl.push_back(mk(1, B+6, 32'h00001234, 2'd1, 3'd0, 32'h0, 0));
        tbl.push_back(mk(0, B+4, 32'h0, 2'd0, 3'd0, 32'h123480EF, 0));
        tbl.push_back(mk(0, B+6, 32'h0, 2'd0, 3'd1, 32'h00001234, 0));
        tbl.push_back(mk(1, B+6, 32'h00008000, 2'd1, 3'd0, 32'h0, 0));
        tbl.push_back(mk(0, B+6, 32'h0, 2'd0, 3'd1, 32'hFFFF8000, 0));
        tbl.push_back(mk(0, B+6, 32'h0, 2'd0, 3'd2, 32'h00008000, 0));
        tbl.push_back(mk(1, B,   32'hA5A5A5A5, 2'd0, 3'd0, 32'h0, 0));
        tbl.push_back(mk(0, B+2, 32'h0, 2'd0, 3'd0, ALIGN ? 32'h0 : 32'hA5A5A5A5, ALIGN));
        tbl.push_back(mk(1, B+1, 32'hFFFFFFFF, 2'd0, 3'd0, 32'h0, ALIGN));
        tbl.push_back(mk(0, B,   32'h0, 2'd0, 3'd0, ALIGN ? 32'hA5A5A5A5 : 32'hFFFFFFFF, 0));
        tbl.push_back(mk(0, 32'h0, 32'h0, 2'd0, 3'd0, 32'h0, 1));
        tbl.push_back(mk(1, B,   32'h12345678, 2'd3, 3'd0, 32'h0, 1));
        tbl.push_back(mk(0, B,   32'h0, 2'd0, 3'd0, ALIGN ? 32'hA5A5A5A5 : 32'hFFFFFFFF, 0));
        tbl.push_back(mk(0, B+6, 32'h0, 2'd0, 3'd0, ALIGN ? 32'h0 : 32'h800080EF, ALIGN));
        tbl.push_back(mk(0, B+4, 32'h0, 2'd0, 3'd5, 32'h0, 1));
        tbl.push_back(mk(1, B+4092, 32'h0BADF00D, 2'd0, 3'd0, 32'h0, 0));
        tbl.push_back(mk(0, B+4092, 32'h0, 2'd0, 3'd0, 32'h0BADF00D, 0));
        tbl.push_back(mk(0, B+4096, 32'h0, 2'd0, 3'd0, 32'h0, 1));
        tbl.push_back(mk(0, B-1, 32'h0, 2'd0, 3'd4, 32'h0, 1));
        tbl.push_back(mk(1, B+3, 32'h0000005A, 2'd2, 3'd0, 32'h0, 0));
        tbl.push_back(mk(0, B+3, 32'h0, 2'd0, 3'd3, 32'h0000005A, 0));

        foreach (tbl[i]) begin
            ref_access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].l, mrd, me, known);
            txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].l, rd, e);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].erd);
            chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, tbl[i].eerr});
        end

        // req held high: one acceptance per ready window, each answered once
        ref_access(1'b0, B+4, 32'h0, 2'd0, 3'd0, mrd, me, known);
        @(negedge clk);
        req = 1'b1; DM_W = 1'b0; addr = B+4; DML_mux = 3'd0; DMS_mux = 2'd0;
        acc = 0; acks = 0;
        for (int i = 0; i < 20; i++) begin
            bit rdy_pre;
            rdy_pre = ready;
            @(posedge clk);
            if (rdy_pre) acc++;
            #1;
            if (ack) begin acks++; chk("busy_rdata", rdata, mrd); end
            @(negedge clk);
        end
        req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ack) begin acks++; chk("busy_rdata", rdata, mrd); end
        end
        chk("busy_accepts", 32'(acc), 32'((20 + LAT + 1) / (LAT + 2)));
        chk("busy_acks", 32'(acks), 32'(acc));

        // Reset during WAIT of a store: aborted, no ack, word unchanged
        ref_access(1'b1, B+8, 32'h22222222, 2'd0, 3'd0, mrd, me, known);
        txn(1'b1, B+8, 32'h22222222, 2'd0, 3'd0, rd, e);
        @(negedge clk);
        req = 1'b1; DM_W = 1'b1; addr = B+8; wdata = 32'h11111111; DMS_mux = 2'd0;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("abort_ready", {31'h0, ready}, 32'h1);
        chk("abort_ack",   {31'h0, ack},   32'h0);
        chk("abort_rdata", rdata,          32'h0);
        #1 rst = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'h0);
        ref_access(1'b0, B+8, 32'h0, 2'd0, 3'd0, mrd, me, known);
        txn(1'b0, B+8, 32'h0, 2'd0, 3'd0, rd, e);
        chk("abort_word_kept", rd, 32'h22222222);
        chk("abort_word_model", rd, mrd);

        // Prefill a 16-word window, then random traffic against the model
        for (int w = 0; w < 16; w++) begin
            logic [31:0] dv;
            dv = $urandom;
            ref_access(1'b1, B + 32'(4*w), dv, 2'd0, 3'd0, mrd, me, known);
            txn(1'b1, B + 32'(4*w), dv, 2'd0, 3'd0, rd, e);
            chk("prefill_err", {31'h0, e}, 32'h0);
        end
        for (int t = 0; t < 150; t++) begin
            logic w; logic [31:0] a, dv; logic [1:0] s; logic [2:0] l; int r;
            w  = 1'($urandom_range(0, 1));
            dv = $urandom;
            s  = 2'($urandom_range(0, 3));
            l  = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r == 0)      a = B - 32'($urandom_range(1, 8));
            else if (r == 1) a = B + 32'(4*DEPTH - 4) + 32'($urandom_range(0, 8));
            else             a = B + 32'($urandom_range(0, 63));
            ref_access(w, a, dv, s, l, mrd, me, known);
            txn(w, a, dv, s, l, rd, e);
            chk($sformatf("rand%0d_err", t), {31'h0, e}, {31'h0, me});
            if (known) chk($sformatf("rand%0d_rdata", t), rd, mrd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
